mux_post_alu: RTL and testbench

MUX_POST_ALU -- requirements
Module: mux_post_alu

---
 rtl/mux_post_alu.sv | 115 +++++++++++
 tb/tb_mux_post_alu.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_post_alu.sv
// Post-ALU datapath registers (PC, ALUOut, MDR) with a 2-entry register-file writeback queue.
// Define BRANCH_NE_EN to add the C_PCWriteCondNE input (branch when the ALU result is non-zero).
module mux_post_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] D_ALU_Result,
    input  logic        D_ALU_Zero,
    input  logic [15:0] D_MemData,
    input  logic [3:0]  D_WriteReg,
    input  logic        C_ALUOutWrite,
    input  logic        C_MDRWrite,
    input  logic        C_PCWrite,
    input  logic        C_PCWriteCond,
`ifdef BRANCH_NE_EN
    input  logic        C_PCWriteCondNE,
`endif
    input  logic [1:0]  C_PCSrc,
    input  logic [1:0]  C_MemToReg,
    input  logic        C_RegWrite,
    input  logic        RF_Ready,
    output logic [15:0] PC,
    output logic [15:0] ALUOut,
    output logic [15:0] MDR,
    output logic        RF_WE,
    output logic [3:0]  RF_WAddr,
    output logic [15:0] RF_WData,
    output logic        C_Stall
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] aluOut_q, aluOut_d;
    logic [15:0] mdr_q, mdr_d;
    logic [3:0]  addrMem_q [2];
    logic [15:0] dataMem_q [2];
    logic        wrPtr_q, wrPtr_d;
    logic        rdPtr_q, rdPtr_d;
    logic [1:0]  count_q, count_d;

    logic        pcLoad;
    logic [15:0] pcNext;
    logic [15:0] wbData;
    logic        pushEn;
    logic        popEn;

    always_comb begin
        pcLoad = C_PCWrite || (C_PCWriteCond && D_ALU_Zero);
`ifdef BRANCH_NE_EN
        pcLoad = pcLoad || (C_PCWriteCondNE && !D_ALU_Zero);
`endif
        // Source 11 means "hold", so a load with that source is a no-op.
        case (C_PCSrc)
            2'b00:   pcNext = D_ALU_Result;
            2'b01:   pcNext = aluOut_q;
            2'b10:   pcNext = {pc_q[15:12], aluOut_q[11:0]};
            default: pcNext = pc_q;
        endcase
        pc_d     = pcLoad ? pcNext : pc_q;
        aluOut_d = C_ALUOutWrite ? D_ALU_Result : aluOut_q;
        mdr_d    = C_MDRWrite ? D_MemData : mdr_q;

        case (C_MemToReg)
            2'b00:   wbData = aluOut_q;
            2'b01:   wbData = mdr_q;
            2'b10:   wbData = pc_q;
            default: wbData = 16'h0000;
        endcase

        // A push into a full queue is only accepted when the head drains on the same edge.
        popEn   = (count_q != 2'd0) && RF_Ready;
        pushEn  = C_RegWrite && ((count_q != 2'd2) || popEn);
        wrPtr_d = pushEn ? ~wrPtr_q : wrPtr_q;
        rdPtr_d = popEn ? ~rdPtr_q : rdPtr_q;
        count_d = count_q;
        if (pushEn && !popEn) begin
            count_d = count_q + 2'd1;
        end else if (popEn && !pushEn) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q      <= 16'h0000;
            aluOut_q  <= 16'h0000;
            mdr_q     <= 16'h0000;
            wrPtr_q   <= 1'b0;
            rdPtr_q   <= 1'b0;
            count_q   <= 2'd0;
            for (int i = 0; i < 2; i++) begin
                addrMem_q[i] <= 4'h0;
                dataMem_q[i] <= 16'h0000;
            end
        end else begin
            pc_q     <= pc_d;
            aluOut_q <= aluOut_d;
            mdr_q    <= mdr_d;
            wrPtr_q  <= wrPtr_d;
            rdPtr_q  <= rdPtr_d;
            count_q  <= count_d;
            if (pushEn) begin
                addrMem_q[wrPtr_q] <= D_WriteReg;
                dataMem_q[wrPtr_q] <= wbData;
            end
        end
    end

    assign PC       = pc_q;
    assign ALUOut   = aluOut_q;
    assign MDR      = mdr_q;
    assign RF_WE    = (count_q != 2'd0);
    assign RF_WAddr = RF_WE ? addrMem_q[rdPtr_q] : 4'h0;
    assign RF_WData = RF_WE ? dataMem_q[rdPtr_q] : 16'h0000;
    assign C_Stall  = (count_q == 2'd2);

endmodule

// File: tb/tb_mux_post_alu.sv
// Directed self-checking bench for mux_post_alu: PC sourcing, branch conditions and the writeback queue.
module tb_mux_post_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] D_ALU_Result;
    logic        D_ALU_Zero;
    logic [15:0] D_MemData;
    logic [3:0]  D_WriteReg;
    logic        C_ALUOutWrite;
    logic        C_MDRWrite;
    logic        C_PCWrite;
    logic        C_PCWriteCond;
`ifdef BRANCH_NE_EN
    logic        C_PCWriteCondNE;
`endif
    logic [1:0]  C_PCSrc;
    logic [1:0]  C_MemToReg;
    logic        C_RegWrite;
    logic        RF_Ready;
    logic [15:0] PC;
    logic [15:0] ALUOut;
    logic [15:0] MDR;
    logic        RF_WE;
    logic [3:0]  RF_WAddr;
    logic [15:0] RF_WData;
    logic        C_Stall;

    int testsRun  = 0;
    int failCount = 0;

    mux_post_alu dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .D_ALU_Result   (D_ALU_Result),
        .D_ALU_Zero     (D_ALU_Zero),
        .D_MemData      (D_MemData),
        .D_WriteReg     (D_WriteReg),
        .C_ALUOutWrite  (C_ALUOutWrite),
        .C_MDRWrite     (C_MDRWrite),
        .C_PCWrite      (C_PCWrite),
        .C_PCWriteCond  (C_PCWriteCond),
`ifdef BRANCH_NE_EN
        .C_PCWriteCondNE(C_PCWriteCondNE),
`endif
        .C_PCSrc        (C_PCSrc),
        .C_MemToReg     (C_MemToReg),
        .C_RegWrite     (C_RegWrite),
        .RF_Ready       (RF_Ready),
        .PC             (PC),
        .ALUOut         (ALUOut),
        .MDR            (MDR),
        .RF_WE          (RF_WE),
        .RF_WAddr       (RF_WAddr),
        .RF_WData       (RF_WData),
        .C_Stall        (C_Stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic checkQueue(input string tag, input logic we, input logic [3:0] addr,
                              input logic [15:0] data, input logic stall);
        checkOutput({tag, ".we"},    {15'd0, RF_WE},   {15'd0, we});
        checkOutput({tag, ".addr"},  {12'd0, RF_WAddr}, {12'd0, addr});
        checkOutput({tag, ".data"},  RF_WData,          data);
        checkOutput({tag, ".stall"}, {15'd0, C_Stall}, {15'd0, stall});
    endtask

    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    task automatic clearControls();
        C_ALUOutWrite = 1'b0;
        C_MDRWrite    = 1'b0;
        C_PCWrite     = 1'b0;
        C_PCWriteCond = 1'b0;
`ifdef BRANCH_NE_EN
        C_PCWriteCondNE = 1'b0;
`endif
        C_PCSrc       = 2'b00;
        C_MemToReg    = 2'b00;
        C_RegWrite    = 1'b0;
    endtask

    initial begin
        rst_n        = 1'b0;
        D_ALU_Result = 16'h0000;
        D_ALU_Zero   = 1'b0;
        D_MemData    = 16'h0000;
        D_WriteReg   = 4'h0;
        RF_Ready     = 1'b0;
        clearControls();
        #12;
        checkOutput("rst.pc", PC, 16'h0000);
        checkOutput("rst.aluout", ALUOut, 16'h0000);
        checkOutput("rst.mdr", MDR, 16'h0000);
        checkQueue("rst", 1'b0, 4'h0, 16'h0000, 1'b0);
        rst_n = 1'b1;

        // Unconditional PC load from the ALU result.
        C_PCWrite = 1'b1; C_PCSrc = 2'b00; D_ALU_Result = 16'h0002;
        applyStimulus();
        checkOutput("pc.uncond", PC, 16'h0002);

        // Load ALUOut, then branch-if-zero with zero low and then high.
        clearControls();
        C_ALUOutWrite = 1'b1; D_ALU_Result = 16'h1234;
        applyStimulus();
        checkOutput("aluout.load", ALUOut, 16'h1234);
        checkOutput("pc.hold", PC, 16'h0002);
        clearControls();
        C_PCWriteCond = 1'b1; C_PCSrc = 2'b01; D_ALU_Zero = 1'b0;
        applyStimulus();
        checkOutput("pc.cond.nz", PC, 16'h0002);
        D_ALU_Zero = 1'b1;
        applyStimulus();
        checkOutput("pc.cond.z", PC, 16'h1234);
        D_ALU_Zero = 1'b0;

        clearControls();
        C_MDRWrite = 1'b1; D_MemData = 16'h5A5A;
        applyStimulus();
        checkOutput("mdr.load", MDR, 16'h5A5A);
        C_MDRWrite = 1'b0; D_MemData = 16'hFFFF;
        applyStimulus();
        checkOutput("mdr.hold", MDR, 16'h5A5A);

        C_PCWrite = 1'b1; C_PCSrc = 2'b11;
        applyStimulus();
        checkOutput("pc.src11", PC, 16'h1234);

        // Fill the queue with RF_Ready low; the third push must be dropped.
        clearControls();
        C_ALUOutWrite = 1'b1; D_ALU_Result = 16'hAAAA;
        applyStimulus();
        C_RegWrite = 1'b1; D_WriteReg = 4'h1; C_MemToReg = 2'b00; D_ALU_Result = 16'hBBBB;
        applyStimulus();
        checkQueue("q.push1", 1'b1, 4'h1, 16'hAAAA, 1'b0);
        D_WriteReg = 4'h2; D_ALU_Result = 16'hCCCC;
        applyStimulus();
        checkQueue("q.push2", 1'b1, 4'h1, 16'hAAAA, 1'b1);
        C_ALUOutWrite = 1'b0; D_WriteReg = 4'h3;
        applyStimulus();
        checkQueue("q.drop3", 1'b1, 4'h1, 16'hAAAA, 1'b1);
        C_RegWrite = 1'b0; RF_Ready = 1'b1;
        applyStimulus();
        checkQueue("q.pop1", 1'b1, 4'h2, 16'hBBBB, 1'b0);
        applyStimulus();
        checkQueue("q.pop2", 1'b0, 4'h0, 16'h0000, 1'b0);
        applyStimulus();
        checkQueue("q.popempty", 1'b0, 4'h0, 16'h0000, 1'b0);

        // Push and ready together on an empty queue only pushes.
        C_RegWrite = 1'b1; D_WriteReg = 4'h5; C_MemToReg = 2'b11;
        applyStimulus();
        checkQueue("q.emptypushpop", 1'b1, 4'h5, 16'h0000, 1'b0);
        C_RegWrite = 1'b0;
        applyStimulus();
        checkQueue("q.drain", 1'b0, 4'h0, 16'h0000, 1'b0);

        // Full queue with simultaneous push and pop keeps the count at two.
        RF_Ready = 1'b0;
        C_RegWrite = 1'b1; D_WriteReg = 4'h1; C_MemToReg = 2'b01;
        applyStimulus();
        D_WriteReg = 4'h2; C_MemToReg = 2'b00;
        applyStimulus();
        checkQueue("q.full", 1'b1, 4'h1, 16'h5A5A, 1'b1);
        D_WriteReg = 4'h4; C_MemToReg = 2'b10; RF_Ready = 1'b1;
        applyStimulus();
        checkQueue("q.fullpushpop", 1'b1, 4'h2, 16'hCCCC, 1'b1);
        C_RegWrite = 1'b0;
        applyStimulus();
        checkQueue("q.tail", 1'b1, 4'h4, 16'h1234, 1'b0);
        applyStimulus();
        checkQueue("q.empty2", 1'b0, 4'h0, 16'h0000, 1'b0);
        RF_Ready = 1'b0;

        // Page-relative jump and PC writeback using the pre-edge PC.
        clearControls();
        C_PCWrite = 1'b1; C_PCSrc = 2'b00; D_ALU_Result = 16'hF000;
        applyStimulus();
        checkOutput("pc.f000", PC, 16'hF000);
        clearControls();
        C_ALUOutWrite = 1'b1; D_ALU_Result = 16'h0ABC;
        applyStimulus();
        clearControls();
        C_PCWrite = 1'b1; C_PCSrc = 2'b10;
        C_RegWrite = 1'b1; D_WriteReg = 4'h7; C_MemToReg = 2'b10;
        applyStimulus();
        checkOutput("pc.page", PC, 16'hFABC);
        checkQueue("q.pcwb", 1'b1, 4'h7, 16'hF000, 1'b0);

        // Asynchronous reset mid-cycle with two entries queued.
        clearControls();
        C_RegWrite = 1'b1; D_WriteReg = 4'h8; C_MemToReg = 2'b01;
        applyStimulus();
        checkQueue("q.twoqueued", 1'b1, 4'h7, 16'hF000, 1'b1);
        C_RegWrite = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkQueue("rst.mid", 1'b0, 4'h0, 16'h0000, 1'b0);
        checkOutput("rst.mid.pc", PC, 16'h0000);
        checkOutput("rst.mid.aluout", ALUOut, 16'h0000);
        checkOutput("rst.mid.mdr", MDR, 16'h0000);
        rst_n = 1'b1;
        C_RegWrite = 1'b1; D_WriteReg = 4'h9; C_MemToReg = 2'b11;
        applyStimulus();
        checkQueue("rst.afterpush", 1'b1, 4'h9, 16'h0000, 1'b0);
        C_RegWrite = 1'b0;
        applyStimulus();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
